// File: rtl/nx_fifo_rr_drain_arb_if.sv
// Bundle between the FIFO bank, the drain arbiter and the downstream engine.
// The master side is the arbiter, and the slave side is the FIFO bank plus the engine.
interface nx_fifo_rr_drain_arb_if #(
  parameter int N_FIFO = 4,
  parameter int WIDTH  = 71,
  parameter int SRC_W  = $clog2(N_FIFO)
);
  logic [N_FIFO-1:0]       fifo_empty;
  logic [N_FIFO*WIDTH-1:0] fifo_rdata;
  logic [N_FIFO-1:0]       fifo_rerr;
  logic [N_FIFO-1:0]       fifo_ren;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_err;
  logic                    locked;

  modport master (
    input  fifo_empty, fifo_rdata, fifo_rerr, out_ready,
    output fifo_ren, out_valid, out_data, out_src, out_err, locked
  );

  modport slave (
    output fifo_empty, fifo_rdata, fifo_rerr, out_ready,
    input  fifo_ren, out_valid, out_data, out_src, out_err, locked
  );
endinterface

// File: rtl/nx_fifo_rr_drain_arb.sv
// Packet-aware round-robin drain of N show-ahead FIFOs into one registered stream.
// Latency 1 from pop to output; the pop is suppressed whenever the output register cannot load.
module nx_fifo_rr_drain_arb #(
  parameter int N_FIFO  = 4,
  parameter int WIDTH   = 71,
  parameter int EOP_BIT = 70
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  nx_fifo_rr_drain_arb_if.master  bus
);
  localparam int SRC_W = $clog2(N_FIFO);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [SRC_W-1:0]   out_src_q;
  logic               out_err_q;
  logic               locked_q;

  logic               load;
  logic               found;
  logic [SRC_W-1:0]   hit_idx;
  logic [SRC_W:0]     cand;
  logic [SRC_W-1:0]   pop_idx;
  logic               pop;
  logic [WIDTH-1:0]   pop_word;
  logic               pop_err;
  logic [SRC_W-1:0]   next_ptr;
  logic [N_FIFO-1:0]  ren;

  assign load = !out_valid_q || bus.out_ready;

  // Rotating priority search; the candidate index is reduced mod N_FIFO by hand so
  // that non-power-of-two FIFO counts wrap correctly.
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_FIFO; k++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(N_FIFO)) begin
        cand = cand - (SRC_W+1)'(N_FIFO);
      end
      if (!found && !bus.fifo_empty[cand[SRC_W-1:0]]) begin
        found   = 1'b1;
        hit_idx = cand[SRC_W-1:0];
      end
    end
  end

  assign pop_idx = (state == LOCKED) ? grant : hit_idx;

  always_comb begin
    pop = 1'b0;
    if (!clear && load) begin
      if (state == LOCKED) begin
        pop = !bus.fifo_empty[grant];
      end else begin
        pop = found;
      end
    end
  end

  always_comb begin
    pop_word = '0;
    pop_err  = 1'b0;
    for (int i = 0; i < N_FIFO; i++) begin
      if (pop_idx == SRC_W'(i)) begin
        pop_word = bus.fifo_rdata[i*WIDTH +: WIDTH];
        pop_err  = bus.fifo_rerr[i];
      end
    end
  end

  assign next_ptr = (pop_idx == SRC_W'(N_FIFO-1)) ? '0 : pop_idx + SRC_W'(1);

  always_comb begin
    ren = '0;
    if (pop) begin
      ren[pop_idx] = 1'b1;
    end
  end

  assign bus.fifo_ren = ren;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else if (clear) begin
      // Arbiter flush only: an un-accepted output word is dropped; FIFO contents stay.
      state       <= IDLE;
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      out_data_q  <= pop_word;
      out_src_q   <= pop_idx;
      out_err_q   <= pop_err;
      if (pop_word[EOP_BIT]) begin
        state    <= IDLE;
        locked_q <= 1'b0;
        rr_ptr   <= next_ptr;
      end else begin
        state    <= LOCKED;
        locked_q <= 1'b1;
        grant    <= pop_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_err   = out_err_q;
  assign bus.locked    = locked_q;

endmodule
